// File: rtl/if_msg_collector_pkg.sv
// ---------------------------------------------------------------------------
// if_msg_collector_pkg
// Shared constants and types for the interface message collector:
//   SYNC_BYTE  - first byte of every frame (not part of the checksum)
//   MAX_LEN    - slave FIFO depth; a fill count of 0 with have_msg set means full
//   state_t    - frame sequencer states
//   len_to_cnt - maps the 8-bit FIFO fill count to the 7-bit payload count
// ---------------------------------------------------------------------------
package if_msg_collector_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hAA;
    localparam int         MAX_LEN   = 64;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        ADDR,
        LEN,
        PAYLOAD,
        CSUM
    } state_t;

    // A fill count of zero can only be seen while have_msg is high when the
    // FIFO has wrapped its counter, i.e. it holds MAX_LEN words.
    function automatic logic [6:0] len_to_cnt(input logic [7:0] len);
        if (len == 8'd0) begin
            return 7'(MAX_LEN);
        end
        return len[6:0];
    endfunction

endpackage

// File: rtl/if_msg_collector_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Searches the request vector starting at
// the channel just after the last-served index, wrapping at N, and returns the
// first requester found.
// Ports:
//   req         in  N      request vector, bit i = channel i pending
//   last        in  IDX_W  index of the channel served most recently
//   grant_idx   out IDX_W  winning channel (0 when nothing is requested)
//   grant_valid out 1      at least one request is pending
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    // One extra bit so last + offset (at most 2N-1) never overflows.
    localparam int SW = IDX_W + 1;

    logic [IDX_W-1:0] cand_idx [N];
    logic [N-1:0]     cand_req;

    // Candidate gi is the channel at distance gi+1 after last, so candidate 0
    // has the highest priority and candidate N-1 (last itself) the lowest.
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        logic [SW-1:0] sum;
        assign sum          = {1'b0, last} + SW'(gi + 1);
        assign cand_idx[gi] = (sum >= SW'(N)) ? IDX_W'(sum - SW'(N)) : IDX_W'(sum);
        assign cand_req[gi] = req[cand_idx[gi]];
    end

    // Scan from lowest to highest priority so the nearest requester wins.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                grant_idx   = cand_idx[k];
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_msg_collector.sv
// ---------------------------------------------------------------------------
// if_msg_collector
// Collects messages from N show-ahead slave FIFOs. Pending channels are
// served round-robin; the winner's FIFO is drained into one framed byte
// stream on a valid/ready link:
//   AA, ADDR_BASE+idx, len, payload[0..len-1], XOR(addr, len, payload)
// Ports:
//   clk           in  1    rising-edge clock
//   n_rst         in  1    asynchronous active-low reset
//   have_msg_bus  in  N    channel i FIFO non-empty
//   len_bus       in  8N   channel i fill count in [8i+7:8i] (0 = full, 64)
//   s_dout_bus    in  8N   channel i FIFO head word in [8i+7:8i]
//   s_rdreq_bus   out N    combinational pop strobe, at most one bit high
//   tx_data       out 8    registered frame byte
//   tx_valid      out 1    registered byte valid
//   tx_ready      in  1    sink accepts on tx_valid & tx_ready
//   busy          out 1    high from grant until the checksum is accepted
// ---------------------------------------------------------------------------
module if_msg_collector
    import if_msg_collector_pkg::*;
#(
    parameter int         N         = 4,
    parameter logic [7:0] ADDR_BASE = 8'h10
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic [N-1:0]   have_msg_bus,
    input  logic [8*N-1:0] len_bus,
    input  logic [8*N-1:0] s_dout_bus,
    output logic [N-1:0]   s_rdreq_bus,
    output logic [7:0]     tx_data,
    output logic           tx_valid,
    input  logic           tx_ready,
    output logic           busy
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    // Per-channel views of the packed buses.
    logic [7:0] len_arr  [N];
    logic [7:0] dout_arr [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign len_arr[gi]  = len_bus[8*gi +: 8];
        assign dout_arr[gi] = s_dout_bus[8*gi +: 8];
    end

    state_t           state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [IDX_W-1:0] last_reg;
    logic [6:0]       cnt_reg;
    // Payload bytes still to be presented, counting the one currently on
    // tx_data while in PAYLOAD.
    logic [6:0]       remaining_reg;
    logic [7:0]       csum_reg;
    logic [7:0]       tx_data_reg;
    logic             tx_valid_reg;
    logic             busy_reg;

    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic [6:0]       grant_cnt;
    logic [7:0]       grant_addr;
    logic             accept;
    logic             pop;
    logic [7:0]       head_byte;

    rr_arbiter #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_arb (
        .req         (have_msg_bus),
        .last        (last_reg),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign grant_cnt  = len_to_cnt(len_arr[grant_idx]);
    assign grant_addr = ADDR_BASE + 8'(grant_idx);
    assign accept     = tx_valid_reg & tx_ready;
    assign head_byte  = dout_arr[idx_reg];

    // Pop exactly when a payload byte is loaded from the FIFO head: on the
    // LEN accept and on each PAYLOAD accept that is not the last byte.
    always_comb begin
        pop = 1'b0;
        if (accept) begin
            if (state_reg == LEN) begin
                pop = 1'b1;
            end else if ((state_reg == PAYLOAD) && (remaining_reg > 7'd1)) begin
                pop = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_rdreq
        assign s_rdreq_bus[gi] = pop && (idx_reg == IDX_W'(gi));
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            last_reg      <= IDX_W'(N - 1);
            cnt_reg       <= '0;
            remaining_reg <= '0;
            csum_reg      <= '0;
            tx_data_reg   <= '0;
            tx_valid_reg  <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        idx_reg       <= grant_idx;
                        cnt_reg       <= grant_cnt;
                        remaining_reg <= grant_cnt;
                        // Seed the checksum with the address and length bytes.
                        csum_reg      <= grant_addr ^ {1'b0, grant_cnt};
                        tx_data_reg   <= SYNC_BYTE;
                        tx_valid_reg  <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= SYNC;
                    end
                end
                SYNC: begin
                    if (accept) begin
                        tx_data_reg <= ADDR_BASE + 8'(idx_reg);
                        state_reg   <= ADDR;
                    end
                end
                ADDR: begin
                    if (accept) begin
                        tx_data_reg <= {1'b0, cnt_reg};
                        state_reg   <= LEN;
                    end
                end
                LEN: begin
                    if (accept) begin
                        tx_data_reg <= head_byte;
                        csum_reg    <= csum_reg ^ head_byte;
                        state_reg   <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        if (remaining_reg > 7'd1) begin
                            tx_data_reg   <= head_byte;
                            csum_reg      <= csum_reg ^ head_byte;
                            remaining_reg <= remaining_reg - 7'd1;
                        end else begin
                            tx_data_reg <= csum_reg;
                            state_reg   <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        tx_valid_reg <= 1'b0;
                        busy_reg     <= 1'b0;
                        last_reg     <= idx_reg;
                        state_reg    <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign tx_data  = tx_data_reg;
    assign tx_valid = tx_valid_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_if_msg_collector.sv
`timescale 1ns/1ps
module tb_if_msg_collector;

    localparam int         N         = 4;
    localparam logic [7:0] ADDR_BASE = 8'h10;
    localparam int         MAXCYC    = 3000;

    logic           clk = 1'b0;
    logic           n_rst = 1'b0;
    logic [N-1:0]   have_msg_bus = '0;
    logic [8*N-1:0] len_bus = '0;
    logic [8*N-1:0] s_dout_bus = '0;
    logic [N-1:0]   s_rdreq_bus;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready = 1'b1;
    logic           busy;

    if_msg_collector #(.N(N), .ADDR_BASE(ADDR_BASE)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .have_msg_bus (have_msg_bus),
        .len_bus      (len_bus),
        .s_dout_bus   (s_dout_bus),
        .s_rdreq_bus  (s_rdreq_bus),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Behavioural slave FIFOs: ring storage with free-running pointers.
    logic [7:0] mem [N][256];
    int         wr_ptr [N];
    int         rd_ptr [N];
    int         pop_cnt [N];
    logic [N-1:0] pend_pop = '0;

    logic [7:0] cap_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] ref_q [$];
    logic       rdy_pat [$];
    int         ready_mode = 0;   // 0 always ready, 1 random, 2 pattern
    int         busy_cycles = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] held_byte = '0;
    int         mlast = N - 1;
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor / FIFO model. Pops seen before a rising edge are applied at the
    // following falling edge; outputs are sampled 2ns after the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (pend_pop[i]) begin
                rd_ptr[i]++;
                pop_cnt[i]++;
            end
        end
        pend_pop = '0;
        if (ready_mode == 1)
            tx_ready = ($urandom_range(0, 99) < 70);
        else if (ready_mode == 2 && tx_valid && rdy_pat.size() > 0)
            tx_ready = rdy_pat.pop_front();
        else
            tx_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            int fill;
            fill = wr_ptr[i] - rd_ptr[i];
            have_msg_bus[i]     = (fill > 0);
            len_bus[8*i +: 8]   = (fill == 64) ? 8'd0 : 8'(fill);
            s_dout_bus[8*i +: 8] = (fill > 0) ? mem[i][rd_ptr[i] % 256] : 8'h00;
        end
        if (busy) busy_cycles++;
        #2;
        if (n_rst) begin
            if (stall_prev) begin
                check("hold_valid", {31'd0, tx_valid}, 32'd1);
                check("hold_data", {24'd0, tx_data}, {24'd0, held_byte});
            end
            if (tx_valid && tx_ready) cap_q.push_back(tx_data);
            stall_prev = tx_valid && !tx_ready;
            held_byte  = tx_data;
            if (stall_prev) check("no_pop_stalled", {28'd0, s_rdreq_bus}, 32'd0);
            if (s_rdreq_bus != '0) check("rdreq_onehot", $countones(s_rdreq_bus), 32'd1);
            pend_pop = s_rdreq_bus;
        end else begin
            stall_prev = 1'b0;
            pend_pop   = '0;
        end
    end

    task automatic push(input int ch, input logic [7:0] b);
        mem[ch][wr_ptr[ch] % 256] = b;
        wr_ptr[ch]++;
    endtask

    // Expected frame from the frame format rules.
    task automatic add_frame(input int ch, input int start, input int n);
        logic [7:0] cs;
        logic [7:0] a;
        a  = ADDR_BASE + 8'(ch);
        cs = a ^ 8'(n);
        exp_q.push_back(8'hAA);
        exp_q.push_back(a);
        exp_q.push_back(8'(n));
        for (int j = 0; j < n; j++) begin
            exp_q.push_back(mem[ch][(start + j) % 256]);
            cs ^= mem[ch][(start + j) % 256];
        end
        exp_q.push_back(cs);
    endtask

    // Serve everything currently queued: next pending channel after the last
    // served, whole FIFO content per frame.
    task automatic model_all();
        int mrd [N];
        int c;
        bit any;
        for (int i = 0; i < N; i++) mrd[i] = rd_ptr[i];
        forever begin
            any = 0;
            c = 0;
            for (int k = 1; k <= N; k++) begin
                int cand;
                cand = (mlast + k) % N;
                if (!any && (wr_ptr[cand] - mrd[cand]) > 0) begin
                    any = 1;
                    c = cand;
                end
            end
            if (!any) break;
            add_frame(c, mrd[c], wr_ptr[c] - mrd[c]);
            mrd[c] = wr_ptr[c];
            mlast = c;
        end
    endtask

    task automatic wait_done(input string name);
        int cyc = 0;
        while ((cap_q.size() < exp_q.size() || busy) && cyc < MAXCYC) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_timeout"}, {31'd0, (cyc < MAXCYC)}, 32'd1);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic compare_stream(input string name);
        check({name, "_len"}, cap_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size(); j++)
            if (j < cap_q.size())
                check($sformatf("%s_byte%0d", name, j), {24'd0, cap_q[j]}, {24'd0, exp_q[j]});
        for (int i = 0; i < N; i++)
            check($sformatf("%s_drained%0d", name, i), rd_ptr[i], wr_ptr[i]);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        n_rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_rst = 1'b1;
        mlast = N - 1;
        cap_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        int         ch;
        int         n;
        logic [7:0] base;
        logic [7:0] exp_addr;
        logic [7:0] exp_len;
        logic [7:0] exp_csum;
    } vec_t;

    vec_t vt [5];

    initial begin
        int p0;
        int cyc;
        int r0;
        // Single-channel frames; payload is base, base+1, ...
        vt[0] = '{ch: 2, n: 3,  base: 8'h01, exp_addr: 8'h12, exp_len: 8'h03, exp_csum: 8'h11};
        vt[1] = '{ch: 0, n: 1,  base: 8'h5A, exp_addr: 8'h10, exp_len: 8'h01, exp_csum: 8'h4B};
        vt[2] = '{ch: 3, n: 2,  base: 8'hF0, exp_addr: 8'h13, exp_len: 8'h02, exp_csum: 8'h10};
        vt[3] = '{ch: 1, n: 4,  base: 8'h00, exp_addr: 8'h11, exp_len: 8'h04, exp_csum: 8'h15};
        vt[4] = '{ch: 2, n: 64, base: 8'h00, exp_addr: 8'h12, exp_len: 8'h40, exp_csum: 8'h52};
        for (int i = 0; i < N; i++) begin
            wr_ptr[i] = 0; rd_ptr[i] = 0; pop_cnt[i] = 0;
        end

        // Reset state
        repeat (3) begin @(posedge clk); #1; end
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rdreq", {28'd0, s_rdreq_bus}, 32'd0);
        n_rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check("idle_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Table-driven single-channel frames
        for (int v = 0; v < 5; v++) begin
            do_reset();
            p0 = pop_cnt[vt[v].ch];
            busy_cycles = 0;
            for (int j = 0; j < vt[v].n; j++) push(vt[v].ch, 8'(vt[v].base + 8'(j)));
            for (int j = 0; j < vt[v].n + 4; j++) exp_q.push_back(8'h00);
            wait_done($sformatf("vec%0d", v));
            check($sformatf("vec%0d_size", v), cap_q.size(), vt[v].n + 4);
            if (cap_q.size() == vt[v].n + 4) begin
                check($sformatf("vec%0d_sync", v), {24'd0, cap_q[0]}, 32'hAA);
                check($sformatf("vec%0d_addr", v), {24'd0, cap_q[1]}, {24'd0, vt[v].exp_addr});
                check($sformatf("vec%0d_len", v), {24'd0, cap_q[2]}, {24'd0, vt[v].exp_len});
                for (int j = 0; j < vt[v].n; j++)
                    check($sformatf("vec%0d_pl%0d", v, j), {24'd0, cap_q[3 + j]},
                          {24'd0, 8'(vt[v].base + 8'(j))});
                check($sformatf("vec%0d_csum", v), {24'd0, cap_q[vt[v].n + 3]}, {24'd0, vt[v].exp_csum});
            end
            check($sformatf("vec%0d_pops", v), pop_cnt[vt[v].ch] - p0, vt[v].n);
            check($sformatf("vec%0d_busy_cycles", v), busy_cycles, vt[v].n + 4);
            check($sformatf("vec%0d_busy_end", v), {31'd0, busy}, 32'd0);
        end

        // Round-robin: serve ch0 first, then ch0/ch1/ch3 pending together
        do_reset();
        push(0, 8'h77);
        model_all();
        wait_done("rr_first");
        compare_stream("rr_first");
        cap_q.delete(); exp_q.delete();
        push(0, 8'h30); push(1, 8'h31); push(3, 8'h33);
        model_all();
        wait_done("rr");
        compare_stream("rr");
        if (cap_q.size() == 15) begin
            check("rr_order1", {24'd0, cap_q[1]}, 32'h11);
            check("rr_order2", {24'd0, cap_q[6]}, 32'h13);
            check("rr_order3", {24'd0, cap_q[11]}, 32'h10);
        end

        // Backpressure: same data with and without stalls
        do_reset();
        push(1, 8'hC3); push(1, 8'h5E); push(1, 8'hA1); push(1, 8'h07);
        model_all();
        wait_done("bp_ref");
        compare_stream("bp_ref");
        ref_q = cap_q;
        do_reset();
        push(1, 8'hC3); push(1, 8'h5E); push(1, 8'hA1); push(1, 8'h07);
        model_all();
        rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        ready_mode = 2;
        wait_done("bp");
        ready_mode = 0;
        compare_stream("bp");
        check("bp_same_len", cap_q.size(), ref_q.size());
        for (int j = 0; j < ref_q.size(); j++)
            if (j < cap_q.size())
                check($sformatf("bp_same%0d", j), {24'd0, cap_q[j]}, {24'd0, ref_q[j]});

        // Late writes: length frozen at grant
        do_reset();
        r0 = rd_ptr[0];
        push(0, 8'h21); push(0, 8'h22);
        cyc = 0;
        while (!busy && cyc < 50) begin @(posedge clk); #1; cyc++; end
        check("late_grant", {31'd0, busy}, 32'd1);
        push(0, 8'h23); push(0, 8'h24);
        add_frame(0, r0, 2);
        add_frame(0, r0 + 2, 2);
        mlast = 0;
        wait_done("late");
        compare_stream("late");
        if (cap_q.size() == 12) begin
            check("late_len1", {24'd0, cap_q[2]}, 32'h02);
            check("late_len2", {24'd0, cap_q[8]}, 32'h02);
        end

        // Reset during payload
        do_reset();
        for (int j = 0; j < 6; j++) push(1, 8'(8'h80 + 8'(j)));
        p0 = pop_cnt[1];
        cyc = 0;
        while ((pop_cnt[1] - p0) < 2 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        check("mid_reached_payload", {31'd0, (pop_cnt[1] - p0 >= 2)}, 32'd1);
        @(posedge clk); #1;
        n_rst = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_rdreq", {28'd0, s_rdreq_bus}, 32'd0);
        check("mid_rst_data", {24'd0, tx_data}, 32'd0);
        @(posedge clk); #1;
        r0 = rd_ptr[1];
        repeat (3) begin @(posedge clk); #1; end
        check("mid_rst_no_pops", rd_ptr[1], r0);
        check("mid_rst_rdreq_hold", {28'd0, s_rdreq_bus}, 32'd0);
        cap_q.delete(); exp_q.delete();
        n_rst = 1'b1;
        mlast = N - 1;
        model_all();
        wait_done("mid_after");
        compare_stream("mid_after");
        if (cap_q.size() > 0) check("mid_after_sync", {24'd0, cap_q[0]}, 32'hAA);

        // Randomized traffic against the frame model, pointer carried across
        for (int it = 0; it < 10; it++) begin
            int tot = 0;
            cap_q.delete(); exp_q.delete();
            for (int i = 0; i < N; i++) begin
                int n;
                n = $urandom_range(0, 6);
                if ($urandom_range(0, 11) == 0) n = 64;
                for (int j = 0; j < n; j++) push(i, 8'($urandom));
                tot += n;
            end
            if (tot == 0) push(int'($urandom_range(0, N - 1)), 8'($urandom));
            ready_mode = ($urandom_range(0, 1) == 1) ? 1 : 0;
            model_all();
            wait_done($sformatf("rand%0d", it));
            ready_mode = 0;
            compare_stream($sformatf("rand%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
